// File: rtl/mem_req_arbiter_2to1.sv
// mem_req_arbiter_2to1
// Shares one downstream memory port between two val/rdy requesters. Requests are
// arbitrated round-robin and passed through with no added latency. Memory returns
// responses in request order, so the issuing port of every in-flight request is kept
// in a small in-order FIFO, and the FIFO head routes each response back.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in{0,1}_req_{msg,val,rdy}       requester request channels (rdy is an output)
//   memreq_{msg,val,rdy}            muxed request to memory (rdy is an input)
//   memresp_{msg,val,rdy}           memory response (rdy is an output)
//   in{0,1}_resp_{msg,val,rdy}      responses to the requesters (rdy is an input)
module mem_req_arbiter_2to1 #(
    parameter int unsigned p_req_nbits    = 77,
    parameter int unsigned p_resp_nbits   = 45,
    parameter int unsigned p_max_inflight = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [p_req_nbits-1:0]  in0_req_msg,
    input  logic                    in0_req_val,
    output logic                    in0_req_rdy,
    input  logic [p_req_nbits-1:0]  in1_req_msg,
    input  logic                    in1_req_val,
    output logic                    in1_req_rdy,

    output logic [p_req_nbits-1:0]  memreq_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,

    input  logic [p_resp_nbits-1:0] memresp_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,

    output logic [p_resp_nbits-1:0] in0_resp_msg,
    output logic                    in0_resp_val,
    input  logic                    in0_resp_rdy,
    output logic [p_resp_nbits-1:0] in1_resp_msg,
    output logic                    in1_resp_val,
    input  logic                    in1_resp_rdy
);

    localparam int unsigned PtrW = $clog2(p_max_inflight);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(p_max_inflight);

    logic                      prio_q, prio_d;
    logic                      lock_val_q, lock_val_d;
    logic                      lock_id_q, lock_id_d;
    logic [p_max_inflight-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           head_q, head_d;
    logic [PtrW-1:0]           tail_q, tail_d;
    logic [CntW-1:0]           count_q, count_d;

    logic grant_val;
    logic grant_id;
    logic can_issue;
    logic not_empty;
    logic head_id;
    logic req_fire;
    logic resp_fire;

    // A locked grant overrides arbitration so a presented request is never retracted.
    always_comb begin
        grant_val = 1'b1;
        grant_id  = 1'b0;
        if (lock_val_q) begin
            grant_id = lock_id_q;
        end else if (in0_req_val && in1_req_val) begin
            grant_id = prio_q;
        end else if (in1_req_val) begin
            grant_id = 1'b1;
        end else if (!in0_req_val) begin
            grant_val = 1'b0;
        end
    end

    // Outputs are forced idle while reset is held.
    always_comb begin
        can_issue    = (count_q < MaxCnt);
        not_empty    = (count_q != '0);
        head_id      = fifo_q[head_q];

        memreq_msg   = grant_id ? in1_req_msg : in0_req_msg;
        memreq_val   = ~reset & can_issue & grant_val & (grant_id ? in1_req_val : in0_req_val);
        in0_req_rdy  = ~reset & can_issue & grant_val & ~grant_id & memreq_rdy;
        in1_req_rdy  = ~reset & can_issue & grant_val &  grant_id & memreq_rdy;

        in0_resp_msg = memresp_msg;
        in1_resp_msg = memresp_msg;
        in0_resp_val = ~reset & memresp_val & not_empty & ~head_id;
        in1_resp_val = ~reset & memresp_val & not_empty &  head_id;
        memresp_rdy  = ~reset & not_empty & (head_id ? in1_resp_rdy : in0_resp_rdy);
    end

    assign req_fire  = memreq_val & memreq_rdy;
    assign resp_fire = memresp_val & memresp_rdy;

    always_comb begin
        prio_d     = prio_q;
        lock_val_d = lock_val_q;
        lock_id_d  = lock_id_q;
        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (req_fire) begin
            fifo_d[tail_q] = grant_id;
            tail_d         = tail_q + 1'b1;
            prio_d         = ~grant_id;
            lock_val_d     = 1'b0;
        end else if (memreq_val) begin
            lock_val_d = 1'b1;
            lock_id_d  = grant_id;
        end
        // When the FIFO is full memreq_val is low, so an existing lock is simply held.

        if (resp_fire) begin
            head_d = head_q + 1'b1;
        end

        unique case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            lock_val_q <= 1'b0;
            lock_id_q  <= 1'b0;
            fifo_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_val_q <= lock_val_d;
            lock_id_q  <= lock_id_d;
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        req_fire |-> (count_q < MaxCnt));
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        resp_fire |-> (count_q != '0));
    a_req_stable : assert property (@(posedge clk) disable iff (reset)
        (memreq_val && !memreq_rdy) |=> $stable(memreq_msg));
`endif

endmodule

// File: doc/mem_req_arbiter_2to1.md
Name: mem_req_arbiter_2to1

Overview:
Shares one memory port between two requesters: instruction and data ports of one core, or two cores in the multicore build. Round-robin arbitration of val/rdy memory requests onto a single downstream request port. Responses are routed back to the issuing requester. The downstream memory returns responses in request order, so the block tracks issuing-port IDs in an in-order in-flight FIFO. Message contents, including the opaque field, pass through unmodified.

Parameters:
p_req_nbits, 77, request message width (VC_MEM_REQ_MSG_NBITS(8,32,32))
p_resp_nbits, 45, response message width (VC_MEM_RESP_MSG_NBITS(8,32))
p_max_inflight, 4, max outstanding requests; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in0_req_msg  in  p_req_nbits  requester 0 request
in0_req_val  in  1  requester 0 request valid
in0_req_rdy  out  1  requester 0 request ready
in1_req_msg  in  p_req_nbits  requester 1 request
in1_req_val  in  1  requester 1 request valid
in1_req_rdy  out  1  requester 1 request ready
memreq_msg  out  p_req_nbits  muxed request to memory
memreq_val  out  1  memory request valid
memreq_rdy  in  1  memory request ready
memresp_msg  in  p_resp_nbits  memory response
memresp_val  in  1  memory response valid
memresp_rdy  out  1  memory response ready
in0_resp_msg  out  p_resp_nbits  response to requester 0
in0_resp_val  out  1  response valid to requester 0
in0_resp_rdy  in  1  requester 0 response ready
in1_resp_msg  out  p_resp_nbits  response to requester 1
in1_resp_val  out  1  response valid to requester 1
in1_resp_rdy  in  1  requester 1 response ready

Behaviour:
- Only clk and reset (sync, active-high) are named as such. All state updates occur on the posedge clk.
- State:
  - prio: 1 bit, the favoured port. Reset value 0.
  - lock_val / lock_id: grant lock. Reset value 0 / 0.
  - In-flight FIFO: p_max_inflight entries x 1-bit port ID, with head/tail pointers and a count. Reset to empty.
- Outputs are combinational, 0-cycle latency request path. During and immediately after reset, all val/rdy outputs are 0 and the FIFO is empty.
- Grant selection:
  - If lock_val=1, grant = lock_id.
  - Else, if exactly one inN_req_val is high, grant = that port.
  - If both are high, grant = prio.
  - If neither is high, no grant.
- Request outputs:
  - can_issue = (count < p_max_inflight).
  - memreq_val = can_issue & granted port's req_val. memreq_msg = granted port's msg.
  - inN_req_rdy = can_issue & (grant==N) & memreq_rdy. The non-granted port's rdy is 0.
- Fire = memreq_val & memreq_rdy. On fire:
  - Push the grant ID into the FIFO.
  - prio <= ~grant.
  - lock_val <= 0.
- Lock: if memreq_val=1 and memreq_rdy=0, then lock_val <= 1 and lock_id <= grant. The grant must not change until fire, because val may not be retracted and the message must stay stable.
- Lock escape: if count reaches p_max_inflight while locked, memreq_val drops, but the lock holds. The same port is presented once space frees.
- Response path:
  - head = FIFO head ID. Valid only when count>0.
  - inN_resp_val = memresp_val & (count>0) & (head==N). inN_resp_msg = memresp_msg for both ports.
  - memresp_rdy = (count>0) & head port's resp_rdy.
  - Response fire pops the FIFO.
- Empty FIFO: memresp_rdy=0 and no resp_val is asserted. A stray response stalls.
- Simultaneous push and pop:
  - Allowed. Count is unchanged and both pointers advance.
  - When count==p_max_inflight, push is blocked in that cycle even if a pop occurs. can_issue uses the registered count only.
- Pointers wrap modulo p_max_inflight. Count width is clog2(p_max_inflight)+1.
- Reset mid-operation clears the lock, prio, and FIFO. Outstanding responses arriving after reset are treated as stray.
- Assertions (sim only): FIFO never overflows or underflows; memreq_msg is stable while memreq_val & ~memreq_rdy.

Test Plan:
1. Reset, then in0_req_val=1 with addr 0x1000 and memreq_rdy=1 -> same-cycle memreq_val=1 with addr 0x1000 and in0_req_rdy=1. Memory returns data 0xCAFE -> in0_resp_val=1 with data 0xCAFE, in1_resp_val=0, and count returns to 0.
2. Both ports valid every cycle, memreq_rdy=1 -> grants alternate 0,1,0,1 starting with port 0 after reset. Each port gets 2 of 4 issues.
3. Both valid, memreq_rdy=0 for 3 cycles with grant=1 -> memreq_msg stays at in1's message and in0_req_rdy=0 throughout. On rdy=1, in1 fires, then in0 is granted next.
4. p_max_inflight=4, 4 requests issued with no responses -> 5th request sees memreq_val=0 and in*_req_rdy=0. One response popped -> issue resumes the next cycle.
5. Issue order 0,1,1 and responses returned in order while in1_resp_rdy is held 0 for 2 cycles on the 2nd response -> memresp_rdy=0 during the stall, then the responses deliver to 0, 1, 1 in order.
6. Reset asserted with 2 outstanding requests and a lock active -> next cycle count=0, lock clear, and all val/rdy outputs 0. A response arriving afterwards is not accepted (memresp_rdy=0).
